reg_bus_arbiter: RTL and testbench

Two-port arbiter sharing the single register-bank access bus between the UART register interface (port 0) and the I2C register interface (port 1). Each port's single-cycle `reg_en`/`write_en` strobe is captured into a small per-port request FIFO. Captured requests are issued one at a time to the bank. Read data is returned to the originating port with a valid pulse and held stable. The block sits between both host interfaces and the register bank, replacing the direct wiring from either interface.

---
 rtl/reg_arb_pkg.sv | 19 +
 rtl/reg_req_fifo.sv | 67 ++++++
 rtl/reg_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared definitions for reg_bus_arbiter -- arbiter states, port ids
// and the request record layout.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RDATA = 2'd2
  } arb_state_t;

  localparam logic PORT_UART = 1'b0;
  localparam logic PORT_I2C  = 1'b1;

  // A request record is packed MSB-first as {write_en, address, wdata}.
  function automatic int req_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/reg_req_fifo.sv
// reg_req_fifo: synchronous request FIFO, DEPTH a power of two >= 2.
// Push is accepted when not full, or when full and popped in the same cycle.
module reg_req_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_full;
  logic          r_empty;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = i_pop && !r_empty;
  assign w_do_push = i_push && (!r_full || w_do_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares one register-bank bus between the UART (port 0) and I2C
// (port 1) register interfaces. Define REG_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module reg_bus_arbiter
  import reg_arb_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic [AW-1:0] p0_address,
  input  logic [DW-1:0] p0_wdata,
  input  logic          p0_reg_en,
  input  logic          p0_write_en,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_rvalid,
  output logic          p0_full,
  output logic          p0_overflow,
  input  logic [AW-1:0] p1_address,
  input  logic [DW-1:0] p1_wdata,
  input  logic          p1_reg_en,
  input  logic          p1_write_en,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_rvalid,
  output logic          p1_full,
  output logic          p1_overflow,
  output logic [AW-1:0] bank_address,
  output logic [DW-1:0] bank_wdata,
  output logic          bank_reg_en,
  output logic          bank_write_en,
  input  logic [DW-1:0] bank_rdata,
  output logic [1:0]    grant_mon,
  output logic [1:0]    o_dbg_state
);

  localparam int RW = req_width(AW, DW);

  typedef struct packed {
    logic          write_en;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata;
  } req_t;

  req_t       w_in0, w_in1, w_head0, w_head1, w_win_req;
  logic       w_full0, w_full1, w_empty0, w_empty1;
  logic       w_pop0, w_pop1, w_grant, w_win;

  arb_state_t    r_state;
  logic          r_last_grant;
  logic          r_cur_we;
  logic [AW-1:0] r_bank_address;
  logic [DW-1:0] r_bank_wdata;
  logic          r_bank_reg_en;
  logic          r_bank_write_en;
  logic [DW-1:0] r_p0_rdata, r_p1_rdata;
  logic          r_p0_rvalid, r_p1_rvalid;
  logic          r_p0_overflow, r_p1_overflow;
  logic [1:0]    r_grant_mon;

  assign w_in0 = '{write_en: p0_write_en, address: p0_address, wdata: p0_wdata};
  assign w_in1 = '{write_en: p1_write_en, address: p1_address, wdata: p1_wdata};

  reg_req_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .resetb(resetb), .i_push(p0_reg_en), .i_pop(w_pop0),
    .i_din(w_in0), .o_dout(w_head0), .o_full(w_full0), .o_empty(w_empty0)
  );

  reg_req_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .resetb(resetb), .i_push(p1_reg_en), .i_pop(w_pop1),
    .i_din(w_in1), .o_dout(w_head1), .o_full(w_full1), .o_empty(w_empty1)
  );

  always_comb begin
    w_win = PORT_UART;
`ifdef REG_ARB_FIXED_PRIO_EN
    if (w_empty0) w_win = PORT_I2C;
`else
    if (!w_empty0 && !w_empty1) w_win = ~r_last_grant;
    else if (w_empty0)          w_win = PORT_I2C;
`endif
  end

  assign w_grant   = (r_state == ARB_IDLE) && !(w_empty0 && w_empty1);
  assign w_pop0    = w_grant && (w_win == PORT_UART);
  assign w_pop1    = w_grant && (w_win == PORT_I2C);
  assign w_win_req = (w_win == PORT_I2C) ? w_head1 : w_head0;

  // Bank strobes and rvalid pulses default low every cycle; states raise them for one cycle.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_state         <= ARB_IDLE;
      r_last_grant    <= PORT_I2C;
      r_cur_we        <= 1'b0;
      r_bank_address  <= '0;
      r_bank_wdata    <= '0;
      r_bank_reg_en   <= 1'b0;
      r_bank_write_en <= 1'b0;
      r_p0_rdata      <= '0;
      r_p1_rdata      <= '0;
      r_p0_rvalid     <= 1'b0;
      r_p1_rvalid     <= 1'b0;
      r_grant_mon     <= '0;
    end else begin
      r_bank_reg_en   <= 1'b0;
      r_bank_write_en <= 1'b0;
      r_p0_rvalid     <= 1'b0;
      r_p1_rvalid     <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_grant) begin
            r_bank_address  <= w_win_req.address;
            r_bank_wdata    <= w_win_req.wdata;
            r_bank_reg_en   <= 1'b1;
            r_bank_write_en <= w_win_req.write_en;
            r_cur_we        <= w_win_req.write_en;
            r_last_grant    <= w_win;
            r_grant_mon     <= {1'b1, w_win};
            r_state         <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (r_cur_we) begin
            r_grant_mon <= {1'b0, r_last_grant};
            r_state     <= ARB_IDLE;
          end else begin
            r_state <= ARB_RDATA;
          end
        end
        ARB_RDATA: begin
          if (r_last_grant == PORT_I2C) begin
            r_p1_rdata  <= bank_rdata;
            r_p1_rvalid <= 1'b1;
          end else begin
            r_p0_rdata  <= bank_rdata;
            r_p0_rvalid <= 1'b1;
          end
          r_grant_mon <= {1'b0, r_last_grant};
          r_state     <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_p0_overflow <= 1'b0;
      r_p1_overflow <= 1'b0;
    end else begin
      if (p0_reg_en && w_full0 && !w_pop0) r_p0_overflow <= 1'b1;
      if (p1_reg_en && w_full1 && !w_pop1) r_p1_overflow <= 1'b1;
    end
  end

  assign p0_rdata      = r_p0_rdata;
  assign p0_rvalid     = r_p0_rvalid;
  assign p0_full       = w_full0;
  assign p0_overflow   = r_p0_overflow;
  assign p1_rdata      = r_p1_rdata;
  assign p1_rvalid     = r_p1_rvalid;
  assign p1_full       = w_full1;
  assign p1_overflow   = r_p1_overflow;
  assign bank_address  = r_bank_address;
  assign bank_wdata    = r_bank_wdata;
  assign bank_reg_en   = r_bank_reg_en;
  assign bank_write_en = r_bank_write_en;
  assign grant_mon     = r_grant_mon;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed and random stimulus for reg_bus_arbiter, checked each
// cycle against a queue-based reference model of the arbiter and a bank memory model.
module tb_reg_bus_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          resetb;
  logic [AW-1:0] p0_address, p1_address;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_reg_en, p1_reg_en, p0_write_en, p1_write_en;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          p0_rvalid, p1_rvalid, p0_full, p1_full, p0_overflow, p1_overflow;
  logic [AW-1:0] bank_address;
  logic [DW-1:0] bank_wdata;
  logic          bank_reg_en, bank_write_en;
  logic [DW-1:0] bank_rdata;
  logic [1:0]    grant_mon;
  logic [1:0]    dbg_state;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  reg_bus_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetb(resetb),
    .p0_address(p0_address), .p0_wdata(p0_wdata), .p0_reg_en(p0_reg_en),
    .p0_write_en(p0_write_en), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p0_full(p0_full), .p0_overflow(p0_overflow),
    .p1_address(p1_address), .p1_wdata(p1_wdata), .p1_reg_en(p1_reg_en),
    .p1_write_en(p1_write_en), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .p1_full(p1_full), .p1_overflow(p1_overflow),
    .bank_address(bank_address), .bank_wdata(bank_wdata), .bank_reg_en(bank_reg_en),
    .bank_write_en(bank_write_en), .bank_rdata(bank_rdata),
    .grant_mon(grant_mon), .o_dbg_state(dbg_state)
  );

  function automatic logic [7:0] init_val(input int a);
    if (a == 'h22) return 8'h5C;
    return 8'(a * 7 + 3);
  endfunction

  // ---------------- register bank model ----------------
  logic [DW-1:0] bank_mem [256];
  bit            bank_init_done;

  always @(posedge clk) begin
    if (!bank_init_done) begin
      for (int i = 0; i < 256; i++) bank_mem[i] <= init_val(i);
      bank_init_done <= 1'b1;
    end else if (bank_reg_en === 1'b1) begin
      if (bank_write_en === 1'b1) bank_mem[bank_address] <= bank_wdata;
      else                        bank_rdata <= bank_mem[bank_address];
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mreq_t;

  mreq_t             mq0[$], mq1[$];
  logic [AW+DW:0]    exp_q[$];
  logic [DW-1:0]     ref_mem [256];
  int                m_cyc, m_free_from, m_issue_at, m_rv_at;
  logic              m_rv_port, m_last, m_gm_port, m_issue_we, m_ovf0, m_ovf1;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata, m_rv_data, m_rdata0, m_rdata1;
  int                checks, errors;

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    exp_q.delete();
    m_free_from = 0;
    m_issue_at  = -1;
    m_rv_at     = -1;
    m_rv_port   = 1'b0;
    m_last      = 1'b1;
    m_gm_port   = 1'b0;
    m_issue_we  = 1'b0;
    m_ovf0      = 1'b0;
    m_ovf1      = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    m_rv_data   = '0;
    m_rdata0    = '0;
    m_rdata1    = '0;
  endtask

  // Advance the model across one clock edge using the inputs presented in that cycle.
  task automatic model_update();
    int    c;
    logic  w;
    mreq_t r;
    c = m_cyc;
    m_cyc++;
    if (!resetb) begin
      model_reset();
      return;
    end
    if (c >= m_free_from && (mq0.size() + mq1.size()) > 0) begin
`ifdef REG_ARB_FIXED_PRIO_EN
      w = (mq0.size() > 0) ? 1'b0 : 1'b1;
`else
      if (mq0.size() > 0 && mq1.size() > 0) w = !m_last;
      else                                  w = (mq0.size() > 0) ? 1'b0 : 1'b1;
`endif
      r = w ? mq1.pop_front() : mq0.pop_front();
      m_last     = w;
      m_gm_port  = w;
      m_issue_at = c + 1;
      m_issue_we = r.we;
      m_addr     = r.addr;
      m_wdata    = r.wdata;
      exp_q.push_back({r.we, r.addr, r.wdata});
      if (r.we) begin
        ref_mem[r.addr] = r.wdata;
        m_free_from = c + 2;
      end else begin
        m_rv_at     = c + 3;
        m_rv_port   = w;
        m_rv_data   = ref_mem[r.addr];
        m_free_from = c + 3;
      end
    end
    if (p0_reg_en) begin
      if (mq0.size() < DEPTH) mq0.push_back(mreq_t'{p0_write_en, p0_address, p0_wdata});
      else                    m_ovf0 = 1'b1;
    end
    if (p1_reg_en) begin
      if (mq1.size() < DEPTH) mq1.push_back(mreq_t'{p1_write_en, p1_address, p1_wdata});
      else                    m_ovf1 = 1'b1;
    end
    if (m_cyc == m_rv_at) begin
      if (m_rv_port) m_rdata1 = m_rv_data;
      else           m_rdata0 = m_rv_data;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic issuing;
    issuing = (m_cyc == m_issue_at);
    chk("bank_reg_en",   32'(bank_reg_en),   32'(issuing));
    chk("bank_write_en", 32'(bank_write_en), 32'(issuing && m_issue_we));
    chk("bank_address",  32'(bank_address),  32'(m_addr));
    chk("bank_wdata",    32'(bank_wdata),    32'(m_wdata));
    chk("p0_rvalid",     32'(p0_rvalid),     32'(m_cyc == m_rv_at && !m_rv_port));
    chk("p1_rvalid",     32'(p1_rvalid),     32'(m_cyc == m_rv_at && m_rv_port));
    chk("p0_rdata",      32'(p0_rdata),      32'(m_rdata0));
    chk("p1_rdata",      32'(p1_rdata),      32'(m_rdata1));
    chk("p0_full",       32'(p0_full),       32'(mq0.size() == DEPTH));
    chk("p1_full",       32'(p1_full),       32'(mq1.size() == DEPTH));
    chk("p0_overflow",   32'(p0_overflow),   32'(m_ovf0));
    chk("p1_overflow",   32'(p1_overflow),   32'(m_ovf1));
    chk("grant_mon",     32'(grant_mon),     32'({m_cyc < m_free_from, m_gm_port}));
    if (bank_reg_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("bank_unexpected_access", 32'(bank_reg_en), 32'd0);
      end else begin
        chk("bank_access_order", 32'({bank_write_en, bank_address, bank_wdata}),
            32'(exp_q.pop_front()));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_inputs();
    p0_reg_en = 1'b0; p0_write_en = 1'b0; p0_address = '0; p0_wdata = '0;
    p1_reg_en = 1'b0; p1_write_en = 1'b0; p1_address = '0; p1_wdata = '0;
  endtask

  task automatic req0(input logic we, input logic [7:0] a, input logic [7:0] d);
    p0_reg_en = 1'b1; p0_write_en = we; p0_address = a; p0_wdata = d;
  endtask

  task automatic req1(input logic we, input logic [7:0] a, input logic [7:0] d);
    p1_reg_en = 1'b1; p1_write_en = we; p1_address = a; p1_wdata = d;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    m_cyc  = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    clear_inputs();

    resetb = 1'b0;
    ticks(2);
    chk("rst_bank_reg_en", 32'(bank_reg_en), 32'd0);
    chk("rst_grant_mon",   32'(grant_mon),   32'd0);
    chk("rst_p0_full",     32'(p0_full),     32'd0);
    chk("rst_dbg_state",   32'(dbg_state),   32'd0);
    resetb = 1'b1;
    tick();

    // Port 0 write 0x10 <- 0xA5
    req0(1'b1, 8'h10, 8'hA5);
    tick();
    clear_inputs();
    tick();
    chk("wr_bank_address", 32'(bank_address),  32'h10);
    chk("wr_bank_wdata",   32'(bank_wdata),    32'hA5);
    chk("wr_bank_reg_en",  32'(bank_reg_en),   32'd1);
    chk("wr_bank_we",      32'(bank_write_en), 32'd1);
    tick();
    chk("wr_strobe_single", 32'(bank_reg_en), 32'd0);
    chk("wr_no_rvalid",     32'(p0_rvalid),   32'd0);
    ticks(3);

    // Port 1 read 0x22 -> 0x5C in cycle 4
    req1(1'b0, 8'h22, 8'h00);
    tick();
    clear_inputs();
    ticks(3);
    chk("rd_p1_rvalid",   32'(p1_rvalid), 32'd1);
    chk("rd_p1_rdata",    32'(p1_rdata),  32'h5C);
    chk("rd_p0_rdata_hold", 32'(p0_rdata), 32'd0);
    ticks(3);

    // Ties: two reads on each port in consecutive cycles
    req0(1'b0, 8'h01, 8'h00);
    req1(1'b0, 8'h02, 8'h00);
    tick();
    req0(1'b0, 8'h03, 8'h00);
    req1(1'b0, 8'h04, 8'h00);
    tick();
    clear_inputs();
    chk("tie1_port0_first", 32'(bank_address), 32'h01);
    ticks(3);
`ifdef REG_ARB_FIXED_PRIO_EN
    chk("tie2_winner", 32'(bank_address), 32'h03);
`else
    chk("tie2_winner", 32'(bank_address), 32'h02);
`endif
    ticks(12);

    // Port 0 write bursts: 4 then 5 back-to-back
    for (int i = 0; i < 4; i++) begin
      req0(1'b1, 8'(8'h40 + i), 8'($urandom_range(0, 255)));
      tick();
    end
    clear_inputs();
    ticks(10);
    for (int i = 0; i < 5; i++) begin
      req0(1'b1, 8'(8'h50 + i), 8'($urandom_range(0, 255)));
      tick();
    end
    clear_inputs();
    chk("burst_overflow_set", 32'(p0_overflow), 32'd1);
    ticks(10);

    // Reset while a read is in ARB_RDATA, with port 0 requests queued
    req1(1'b0, 8'h33, 8'h00);
    tick();
    clear_inputs();
    req0(1'b1, 8'h60, 8'h11);
    tick();
    req0(1'b1, 8'h61, 8'h22);
    tick();
    clear_inputs();
    chk("mid_rdata_state", 32'(dbg_state), 32'd2);
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    chk("rst_mid_no_rvalid", 32'(p1_rvalid),   32'd0);
    chk("rst_mid_p0_full",   32'(p0_full),     32'd0);
    chk("rst_mid_overflow",  32'(p0_overflow), 32'd0);
    chk("rst_mid_bank_addr", 32'(bank_address), 32'd0);
    ticks(4);
    chk("rst_mid_fifo_empty", 32'(bank_reg_en), 32'd0);
    req0(1'b0, 8'h22, 8'h00);
    tick();
    clear_inputs();
    ticks(3);
    chk("post_rst_p0_rvalid", 32'(p0_rvalid), 32'd1);
    chk("post_rst_p0_rdata",  32'(p0_rdata),  32'h5C);
    ticks(3);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      p0_reg_en   = ($urandom_range(0, 99) < 35);
      p0_write_en = 1'($urandom_range(0, 1));
      p0_address  = 8'($urandom_range(0, 255));
      p0_wdata    = 8'($urandom_range(0, 255));
      p1_reg_en   = ($urandom_range(0, 99) < 35);
      p1_write_en = 1'($urandom_range(0, 1));
      p1_address  = 8'($urandom_range(0, 255));
      p1_wdata    = 8'($urandom_range(0, 255));
      resetb      = ($urandom_range(0, 199) != 0);
      tick();
    end
    clear_inputs();
    resetb = 1'b1;
    ticks(20);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
